alu8_nibble_seq: RTL and testbench

//  Runs 8-bit CPU ALU ops as two passes through the shared 4-bit nibble ALU:
//  low nibble first, then high nibble with the chained carry/borrow.

---
 rtl/alu8_nibble_seq.sv | 143 ++++++++++++++
 tb/tb_alu8_nibble_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu8_nibble_seq.sv
// rtl/alu8_nibble_seq.sv - 8-bit ALU op sequenced as two passes through a shared 4-bit nibble ALU
module alu8_nibble_seq #(
    parameter bit AND_SETS_H = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    input  logic       c_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       result_we,
    output logic       flag_z,
    output logic       flag_n,
    output logic       flag_h,
    output logic       flag_c,
    output logic [3:0] nib_a,
    output logic [3:0] nib_b,
    output logic [2:0] nib_op,
    output logic       nib_cin,
    input  logic [3:0] nib_out,
    input  logic       nib_cout
);
    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_CP  = 3'd7;

    state_t     state_q;
    logic [2:0] op_q;
    logic [7:0] a_q, b_q;
    logic       c_q;
    logic [3:0] lo_q;
    logic       hc_q;
    logic       busy_q, done_q, we_q;
    logic [7:0] result_q;
    logic       z_q, n_q, h_q, c_q_flag;

    logic       is_arith, is_sub, uses_c;
    logic [2:0] nib_op_d;
    logic [7:0] result_d;

    assign is_arith = (op_q[2] == 1'b0) || (op_q == OP_CP);
    assign is_sub   = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP);
    assign uses_c   = (op_q == OP_ADC) || (op_q == OP_SBC);
    assign result_d = {nib_out, lo_q};

    always_comb begin
        nib_op_d = 3'd0;
        case (op_q)
            3'd0, 3'd1:       nib_op_d = 3'd1;
            3'd2, 3'd3, 3'd7: nib_op_d = 3'd3;
            default:          nib_op_d = op_q;
        endcase
    end

    always_comb begin
        nib_a   = 4'd0;
        nib_b   = 4'd0;
        nib_op  = 3'd0;
        nib_cin = 1'b0;
        if (state_q == S_LO) begin
            nib_a   = a_q[3:0];
            nib_b   = b_q[3:0];
            nib_op  = nib_op_d;
            nib_cin = uses_c ? c_q : 1'b0;
        end else if (state_q == S_HI) begin
            nib_a   = a_q[7:4];
            nib_b   = b_q[7:4];
            nib_op  = nib_op_d;
            nib_cin = is_arith ? hc_q : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            a_q      <= 8'd0;
            b_q      <= 8'd0;
            c_q      <= 1'b0;
            lo_q     <= 4'd0;
            hc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            result_q <= 8'd0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            h_q      <= 1'b0;
            c_q_flag <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= a_in;
                        b_q     <= b_in;
                        c_q     <= c_in;
                        busy_q  <= 1'b1;
                        state_q <= S_LO;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LO: begin
                    lo_q    <= nib_out;
                    hc_q    <= nib_cout;
                    state_q <= S_HI;
                end
                S_HI: begin
                    result_q <= result_d;
                    we_q     <= (op_q != OP_CP);
                    z_q      <= (result_d == 8'd0);
                    n_q      <= is_sub;
                    // Half-carry: low-nibble carry/borrow for arithmetic, constant for AND
                    h_q      <= is_arith ? hc_q : ((op_q == OP_AND) ? AND_SETS_H : 1'b0);
                    c_q_flag <= is_arith ? nib_cout : 1'b0;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign result_we = we_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_h    = h_q;
    assign flag_c    = c_q_flag;
endmodule

// File: tb/tb_alu8_nibble_seq.sv
// tb/tb_alu8_nibble_seq.sv - scoreboard bench for alu8_nibble_seq with a nibble ALU model
module tb_alu8_nibble_seq;
    localparam bit AND_SETS_H = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic [7:0] a_in = 8'd0, b_in = 8'd0;
    logic       c_in = 1'b0;
    logic       busy, done, result_we, flag_z, flag_n, flag_h, flag_c;
    logic [7:0] result;
    logic [3:0] nib_a, nib_b, nib_out;
    logic [2:0] nib_op;
    logic       nib_cin, nib_cout;

    alu8_nibble_seq #(.AND_SETS_H(AND_SETS_H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .c_in(c_in), .busy(busy), .done(done), .result(result), .result_we(result_we),
        .flag_z(flag_z), .flag_n(flag_n), .flag_h(flag_h), .flag_c(flag_c),
        .nib_a(nib_a), .nib_b(nib_b), .nib_op(nib_op), .nib_cin(nib_cin),
        .nib_out(nib_out), .nib_cout(nib_cout)
    );

    always #5 clk = ~clk;

    // External 4-bit nibble ALU: 1 add, 3 subtract-with-borrow, 4 and, 5 xor, 6 or
    always_comb begin
        logic [4:0] t;
        t = 5'd0;
        case (nib_op)
            3'd1: t = {1'b0, nib_a} + {1'b0, nib_b} + {4'd0, nib_cin};
            3'd3: t = {1'b0, nib_a} - {1'b0, nib_b} - {4'd0, nib_cin};
            3'd4: t = {1'b0, nib_a & nib_b};
            3'd5: t = {1'b0, nib_a ^ nib_b};
            3'd6: t = {1'b0, nib_a | nib_b};
            default: t = 5'd0;
        endcase
        nib_out  = t[3:0];
        nib_cout = t[4];
    end

    typedef struct packed {
        logic [7:0] res;
        logic       we, z, n, h, c;
    } exp_t;

    typedef struct {
        exp_t e;
        int   cyc;
    } sb_t;

    sb_t sb[$];
    int  tests = 0, fails = 0, cyc = 0, done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int r, input bit we, z, n, h, c);
        exp_t e;
        e.res = r[7:0]; e.we = we; e.z = z; e.n = n; e.h = h; e.c = c;
        return e;
    endfunction

    // Reference: whole-byte arithmetic, flags from the architectural rules
    function automatic exp_t model(input int o, input int a, input int b, input int ci);
        int r, h, c, n;
        h = 0; c = 0; n = 0;
        case (o)
            0, 1: begin
                if (o == 0) ci = 0;
                r = a + b + ci;
                h = ((a % 16) + (b % 16) + ci) > 15;
                c = r > 255;
            end
            2, 3, 7: begin
                if (o != 3) ci = 0;
                r = a - b - ci;
                h = ((a % 16) - (b % 16) - ci) < 0;
                c = r < 0;
                n = 1;
            end
            4: begin r = a & b; h = AND_SETS_H; end
            5: r = a ^ b;
            default: r = a | b;
        endcase
        r = r & 255;
        return mk(r, o != 7, r == 0, n != 0, h != 0, c != 0);
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                sb_t s;
                s = sb.pop_front();
                chk("result", result, s.e.res);
                chk("result_we", result_we, s.e.we);
                chk("flag_z", flag_z, s.e.z);
                chk("flag_n", flag_n, s.e.n);
                chk("flag_h", flag_h, s.e.h);
                chk("flag_c", flag_c, s.e.c);
                chk("latency", cyc - s.cyc, 3);
            end
        end
    end

    task automatic drive(input int o, input int a, input int b, input int c, input exp_t e);
        sb_t s;
        op = o[2:0]; a_in = a[7:0]; b_in = b[7:0]; c_in = c[0]; start = 1'b1;
        s.e = e; s.cyc = cyc;
        sb.push_back(s);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic single(input int o, input int a, input int b, input int c, input exp_t e);
        @(negedge clk);
        drive(o, a, b, c, e);
        @(posedge clk);
        #1 start = 1'b0;
        drain();
    endtask

    initial begin
        int d0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_we", result_we, 0);
        chk("rst_flags", {flag_z, flag_n, flag_h, flag_c}, 0);
        chk("rst_nib", {nib_a, nib_b, nib_op, nib_cin}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        single(0, 8'h3A, 8'hC6, 0, mk(8'h00, 1, 1, 0, 1, 1));
        single(2, 8'h10, 8'h01, 0, mk(8'h0F, 1, 0, 1, 1, 0));
        single(3, 8'h00, 8'h00, 1, mk(8'hFF, 1, 0, 1, 1, 1));
        single(4, 8'hF0, 8'h0F, 0, mk(8'h00, 1, 1, 0, AND_SETS_H, 0));
        single(6, 8'h12, 8'h40, 0, mk(8'h52, 1, 0, 0, 0, 0));

        // CP with a stray start pulse while in LO
        d0 = done_cnt;
        @(negedge clk);
        drive(7, 8'h42, 8'h42, 0, mk(8'h00, 0, 1, 1, 0, 0));
        @(negedge clk);
        chk("busy_in_lo", busy, 1);
        op = 3'd0; a_in = 8'h01; b_in = 8'h01;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (4) @(negedge clk);
        chk("cp_single_done", done_cnt - d0, 1);

        // start held through DONE: back-to-back issue every 3 cycles
        d0 = done_cnt;
        @(negedge clk);
        drive(1, 8'hFF, 8'h00, 1, mk(8'h00, 1, 1, 0, 1, 1));
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            int o, a, b, c;
            o = $urandom_range(0, 7); a = $urandom_range(0, 255);
            b = $urandom_range(0, 255); c = $urandom_range(0, 1);
            drive(o, a, b, c, model(o, a, b, c));
            repeat (3) @(negedge clk);
        end
        start = 1'b0;
        drain();
        chk("b2b_done_count", done_cnt - d0, 6);

        // reset while in HI drops the op
        d0 = done_cnt;
        @(negedge clk);
        op = 3'd0; a_in = 8'h55; b_in = 8'h22; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_flags", {result_we, flag_z, flag_n, flag_h, flag_c}, 0);
        chk("mid_rst_nib", {nib_a, nib_b, nib_op, nib_cin}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_no_done", done_cnt - d0, 0);

        for (int k = 0; k < 150; k++) begin
            int o, a, b, c;
            o = $urandom_range(0, 7); a = $urandom_range(0, 255);
            b = $urandom_range(0, 255); c = $urandom_range(0, 1);
            single(o, a, b, c, model(o, a, b, c));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
